if_id_buffer: RTL and testbench
===============================

IF_ID_BUFFER -- requirements
Module: if_id_buffer

Interface
REQ-001 The block SHALL have parameter NOP_INST, default 32'h00000013, the instruction presented to decode when no entry is valid (addi x0,x0,0).
REQ-002 The block SHALL have port CLK  input  1  single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port RESET  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port IN_VALID  input  1  fetch stage offers an instruction this cycle.
REQ-005 The block SHALL have port IN_READY  output  1  buffer can accept an instruction this cycle.
REQ-006 The block SHALL have port IN_PC  input  32  PC of offered instruction.
REQ-007 The block SHALL have port IN_INST  input  32  offered instruction word.
REQ-008 The block SHALL have port STALL  input  1  decode/hazard unit holds the head entry.
REQ-009 The block SHALL have port FLUSH  input  1  branch/jump redirect; discard all buffered entries.
REQ-010 The block SHALL have port OUT_VALID  output  1  head entry is valid.
REQ-011 The block SHALL have port OUT_PC  output  32  PC of head entry.
REQ-012 The block SHALL have port OUT_PC4  output  32  OUT_PC + 4.
REQ-013 The block SHALL have port OUT_INST  output  32  head instruction word; feeds decode and the immediate generator's INST input.
REQ-014 The block SHALL have port OCCUPANCY  output  2  number of valid entries, 0..2.

Function
REQ-015 The block SHALL be a 2-entry FIFO of {PC, INST} pairs with 1-bit write and read pointers that wrap 1->0.
REQ-016 IN_READY SHALL equal (OCCUPANCY < 2) and SHALL be driven only from registered state, not from STALL, FLUSH or IN_VALID.
REQ-017 A push SHALL occur when IN_VALID && IN_READY && !FLUSH; the entry is written at the write pointer, which then advances.
REQ-018 A pop SHALL occur when OUT_VALID && !STALL && !FLUSH; the read pointer then advances.
REQ-019 Simultaneous push and pop SHALL leave OCCUPANCY unchanged and SHALL preserve FIFO order.
REQ-020 OUT_VALID, OUT_PC and OUT_INST SHALL be read from registered storage at the read pointer, with no combinational path from IN_* to OUT_*.
REQ-021 Fall-through latency SHALL be 1 cycle: an instruction pushed at edge N SHALL appear on OUT_* after edge N when the buffer was empty.
REQ-022 When OCCUPANCY = 0, the block SHALL drive OUT_VALID = 0, OUT_INST = NOP_INST, OUT_PC = 32'h0 and OUT_PC4 = 32'h4.
REQ-023 OUT_PC4 SHALL be OUT_PC + 4 modulo 2^32, so 32'hFFFFFFFC yields 32'h00000000.
REQ-024 While STALL = 1 and FLUSH = 0, OUT_* SHALL hold, and pushes SHALL still be accepted while OCCUPANCY < 2.
REQ-025 FLUSH = 1 SHALL set OCCUPANCY = 0 and both pointers to 0 at the next edge.
REQ-026 During a FLUSH cycle, any offered push SHALL be dropped and FLUSH SHALL override STALL.
REQ-027 When full, IN_READY = 0 and IN_VALID SHALL be ignored, even if a pop occurs in the same cycle.
REQ-028 Entry storage SHALL not be cleared on pop or flush; only pointers and occupancy change.

Reset
REQ-029 While RESET = 1, independent of CLK, the block SHALL force OCCUPANCY = 0, pointers = 0, OUT_VALID = 0, OUT_INST = NOP_INST, OUT_PC = 0, OUT_PC4 = 4 and IN_READY = 1.
REQ-030 RESET asserted with entries buffered SHALL discard them, and no pre-reset entry SHALL reappear after release.
REQ-031 After RESET deasserts, the first push SHALL be accepted on the first rising edge with IN_VALID = 1.

Verification
REQ-032 Reset/empty: the bench SHALL assert RESET mid-cycle with 2 entries buffered -> OUT_VALID = 0, OUT_INST = 32'h00000013, OCCUPANCY = 0 and IN_READY = 1 immediately, before any clock edge.
REQ-033 Streaming: the bench SHALL push PC 0x0/0x4/0x8 (INST 0x00500093, 0x00A00113, 0x002081B3) on consecutive cycles with STALL = 0 -> each appears on OUT_* exactly 1 cycle later, in order, with OCCUPANCY = 1 throughout.
REQ-034 Stall fill: the bench SHALL push 3 instructions with STALL = 1 -> OCCUPANCY = 2, IN_READY = 0, the third not accepted and OUT_PC = 0x0 held; after STALL = 0, OUT_PC advances 0x0 -> 0x4 and IN_READY returns to 1.
REQ-035 Flush: the bench SHALL assert FLUSH with OCCUPANCY = 2, STALL = 1 and IN_VALID = 1 (PC 0x100) -> next cycle OCCUPANCY = 0, OUT_VALID = 0 and PC 0x100 not buffered; a push of PC 0x200 the following cycle appears 1 cycle later.
REQ-036 Wrap and full push/pop: the bench SHALL run 5 push/pop cycles to wrap both pointers, then offer IN_VALID = 1 while full with a pop -> no push, OCCUPANCY = 1, order intact.
REQ-037 PC wrap: the bench SHALL push PC 0xFFFFFFFC -> OUT_PC4 = 0x00000000.

Source files
------------

// File: rtl/if_id_buffer.sv
// if_id_buffer: 2-entry fetch-to-decode FIFO of {PC, INST} with stall and flush
module if_id_buffer #(
    parameter logic [31:0] NOP_INST = 32'h00000013
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        IN_VALID,
    output logic        IN_READY,
    input  logic [31:0] IN_PC,
    input  logic [31:0] IN_INST,
    input  logic        STALL,
    input  logic        FLUSH,
    output logic        OUT_VALID,
    output logic [31:0] OUT_PC,
    output logic [31:0] OUT_PC4,
    output logic [31:0] OUT_INST,
    output logic [1:0]  OCCUPANCY
);
    logic [1:0][31:0] pc_q, pc_d, inst_q, inst_d;
    logic             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [1:0]       occ_q, occ_d;
    logic             push, pop;

    assign IN_READY  = !occ_q[1];
    assign OUT_VALID = occ_q != 2'd0;
    assign OUT_PC    = OUT_VALID ? pc_q[rd_ptr_q] : 32'h0;
    assign OUT_INST  = OUT_VALID ? inst_q[rd_ptr_q] : NOP_INST;
    assign OUT_PC4   = OUT_PC + 32'd4;
    assign OCCUPANCY = occ_q;

    // Handshakes and next state; flush discards the offered push and overrides stall
    always_comb begin
        push   = IN_VALID && IN_READY && !FLUSH;
        pop    = OUT_VALID && !STALL && !FLUSH;
        pc_d   = pc_q;
        inst_d = inst_q;
        if (push) begin
            pc_d[wr_ptr_q]   = IN_PC;
            inst_d[wr_ptr_q] = IN_INST;
        end
        wr_ptr_d = FLUSH ? 1'b0 : wr_ptr_q ^ push;
        rd_ptr_d = FLUSH ? 1'b0 : rd_ptr_q ^ pop;
        occ_d    = FLUSH ? 2'd0 : occ_q + {1'b0, push} - {1'b0, pop};
    end

    // Pointers and occupancy; async reset empties the buffer immediately
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // Entry storage is never cleared; occupancy gates its visibility
    always_ff @(posedge CLK) begin
        pc_q   <= pc_d;
        inst_q <= inst_d;
    end
endmodule

// File: tb/tb_if_id_buffer.sv
// tb_if_id_buffer: directed and randomized checks against a queue-based model
module tb_if_id_buffer;
    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, stall, flush, out_valid;
    logic [31:0] in_pc, in_inst, out_pc, out_pc4, out_inst;
    logic [1:0]  occupancy;
    int          checks = 0, errors = 0;
    logic [63:0] q[$];

    if_id_buffer dut (
        .CLK(clk), .RESET(rst), .IN_VALID(in_valid), .IN_READY(in_ready),
        .IN_PC(in_pc), .IN_INST(in_inst), .STALL(stall), .FLUSH(flush),
        .OUT_VALID(out_valid), .OUT_PC(out_pc), .OUT_PC4(out_pc4),
        .OUT_INST(out_inst), .OCCUPANCY(occupancy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_model(input string tag);
        logic [31:0] pc, inst;
        pc   = q.size() > 0 ? q[0][63:32] : 32'h0;
        inst = q.size() > 0 ? q[0][31:0] : NOP;
        check({tag, "_valid"}, {31'b0, out_valid}, {31'b0, q.size() > 0});
        check({tag, "_pc"}, out_pc, pc);
        check({tag, "_pc4"}, out_pc4, pc + 32'd4);
        check({tag, "_inst"}, out_inst, inst);
        check({tag, "_occ"}, {30'b0, occupancy}, q.size());
        check({tag, "_ready"}, {31'b0, in_ready}, {31'b0, q.size() < 2});
    endtask

    task automatic cycle(input string tag, input logic v, input logic [31:0] pc,
                         input logic [31:0] inst, input logic st, input logic fl);
        bit do_push, do_pop;
        in_valid = v; in_pc = pc; in_inst = inst; stall = st; flush = fl;
        @(posedge clk);
        #1;
        do_push = v && q.size() < 2 && !fl;
        do_pop  = q.size() > 0 && !st && !fl;
        if (fl) q.delete();
        else begin
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back({pc, inst});
        end
        in_valid = 1'b0;
        check_model(tag);
    endtask

    task automatic drain();
        for (int i = 0; i < 3; i++) cycle("drain", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_pc = '0; in_inst = '0; stall = 1'b0; flush = 1'b0;
        #3;
        check_model("reset");
        @(posedge clk);
        #1 rst = 1'b0;

        cycle("stream0", 1'b1, 32'h0, 32'h00500093, 1'b0, 1'b0);
        check("stream0_pc", out_pc, 32'h0);
        cycle("stream1", 1'b1, 32'h4, 32'h00A00113, 1'b0, 1'b0);
        check("stream1_inst", out_inst, 32'h00A00113);
        cycle("stream2", 1'b1, 32'h8, 32'h002081B3, 1'b0, 1'b0);
        check("stream2_pc", out_pc, 32'h8);
        check("stream2_occ", {30'b0, occupancy}, 32'd1);
        drain();

        cycle("sfill0", 1'b1, 32'h0, 32'h11, 1'b1, 1'b0);
        cycle("sfill1", 1'b1, 32'h4, 32'h22, 1'b1, 1'b0);
        cycle("sfill2", 1'b1, 32'h8, 32'h33, 1'b1, 1'b0);
        check("sfill_occ", {30'b0, occupancy}, 32'd2);
        check("sfill_ready", {31'b0, in_ready}, 32'd0);
        check("sfill_hold", out_pc, 32'h0);
        cycle("sfill_rel", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        check("sfill_adv", out_pc, 32'h4);
        check("sfill_ready1", {31'b0, in_ready}, 32'd1);
        drain();

        cycle("fl_fill0", 1'b1, 32'h10, 32'h44, 1'b1, 1'b0);
        cycle("fl_fill1", 1'b1, 32'h14, 32'h55, 1'b1, 1'b0);
        cycle("flush", 1'b1, 32'h100, 32'h66, 1'b1, 1'b1);
        check("flush_occ", {30'b0, occupancy}, 32'd0);
        check("flush_valid", {31'b0, out_valid}, 32'd0);
        cycle("fl_push", 1'b1, 32'h200, 32'h77, 1'b0, 1'b0);
        check("fl_push_pc", out_pc, 32'h200);
        drain();

        cycle("wrap_in", 1'b1, 32'h300, 32'h1000, 1'b0, 1'b0);
        for (int i = 1; i <= 5; i++)
            cycle("wrap", 1'b1, 32'h300 + 32'(4 * i), 32'h1000 + 32'(i), 1'b0, 1'b0);
        cycle("wrap_fill", 1'b1, 32'h318, 32'h1006, 1'b1, 1'b0);
        check("wrap_full", {30'b0, occupancy}, 32'd2);
        cycle("full_pop", 1'b1, 32'h31C, 32'h1007, 1'b0, 1'b0);
        check("full_pop_occ", {30'b0, occupancy}, 32'd1);
        check("full_pop_pc", out_pc, 32'h318);
        drain();

        cycle("pcwrap", 1'b1, 32'hFFFFFFFC, 32'h88, 1'b0, 1'b0);
        check("pcwrap_pc4", out_pc4, 32'h0);
        drain();

        cycle("rst_fill0", 1'b1, 32'h400, 32'h99, 1'b1, 1'b0);
        cycle("rst_fill1", 1'b1, 32'h404, 32'hAA, 1'b1, 1'b0);
        stall = 1'b0;
        #2 rst = 1'b1;
        #1;
        q.delete();
        check_model("midrst");
        check("midrst_inst", out_inst, 32'h00000013);
        @(posedge clk);
        #1 rst = 1'b0;
        cycle("post_rst", 1'b1, 32'h500, 32'hBB, 1'b0, 1'b0);
        check("post_rst_pc", out_pc, 32'h500);
        drain();

        for (int i = 0; i < 400; i++)
            cycle("rand", 1'($urandom_range(0, 1)), $urandom & 32'hFFFFFFFC, $urandom,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 19) == 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
